// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory.
// Master 0 is the core LSU and master 1 is DMA/debug. Grants are combinational.
// Responses come back through a fixed-latency tag pipeline, in acceptance order.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter bit RR_EN       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        busy_o
);

  // Last-granted master: 0 = m0, 1 = m1.
  logic                   last_m1_q;
  logic                   sel_m1;
  logic                   req_any;
  logic                   accept;
  logic [MEM_LATENCY-1:0] vld_p;
  logic [MEM_LATENCY-1:0] id_p;
  logic [MEM_LATENCY-1:0] we_p;
  logic                   rsp_vld;
  logic                   rsp_id;
  logic                   rsp_we;

  // Pick the winner. On a tie, round-robin favours the master not granted last.
  always_comb begin
    sel_m1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      sel_m1 = RR_EN ? ~last_m1_q : 1'b0;
    end else begin
      sel_m1 = m1_req_i;
    end
    req_any = (m0_req_i | m1_req_i) & rst_ni;
    accept  = req_any & dmem_gnt_i;
  end

  // Steer the winner's fields to DMEM. The byte enables are blanked on loads.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_wdata_o = 32'h0;
    dmem_be_o    = 4'h0;
    m0_gnt_o     = 1'b0;
    m1_gnt_o     = 1'b0;
    if (req_any) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = sel_m1 ? m1_we_i    : m0_we_i;
      dmem_addr_o  = sel_m1 ? m1_addr_i  : m0_addr_i;
      dmem_wdata_o = sel_m1 ? m1_wdata_i : m0_wdata_i;
      dmem_be_o    = dmem_we_o ? (sel_m1 ? m1_be_i : m0_be_i) : 4'h0;
      m0_gnt_o     = accept & ~sel_m1;
      m1_gnt_o     = accept &  sel_m1;
    end
  end

  // Control state: the pointer moves only on acceptance. The valid pipeline shifts every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_m1_q <= 1'b1;
      vld_p     <= '0;
    end else begin
      if (accept) begin
        last_m1_q <= sel_m1;
      end
      // stage 0: tag captured on acceptance; later stages follow memory latency
      vld_p[0] <= accept;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Tag payload (id, we) travels alongside vld_p and needs no reset.
  always_ff @(posedge clk_i) begin
    id_p[0] <= sel_m1;
    we_p[0] <= dmem_we_o;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      id_p[i] <= id_p[i-1];
      we_p[i] <= we_p[i-1];
    end
  end

  // Pipeline output: route the response to its owner. Stores return zero data.
  always_comb begin
    rsp_vld     = vld_p[MEM_LATENCY-1] & rst_ni;
    rsp_id      = id_p[MEM_LATENCY-1];
    rsp_we      = we_p[MEM_LATENCY-1];
    m0_rvalid_o = rsp_vld & ~rsp_id;
    m1_rvalid_o = rsp_vld &  rsp_id;
    m0_rdata_o  = (m0_rvalid_o && !rsp_we) ? dmem_rdata_i : 32'h0;
    m1_rdata_o  = (m1_rvalid_o && !rsp_we) ? dmem_rdata_i : 32'h0;
    busy_o      = |vld_p;
  end

  // A pending request must stay asserted until it is granted.
  m0_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m0_req_i && !m0_gnt_o) |=> m0_req_i);
  m1_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m1_req_i && !m1_gnt_o) |=> m1_req_i);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Instance 0: latency 1, round-robin.  Instance 1: latency 1, fixed priority.
// Instance 2: latency 2, round-robin.  Instance 3: latency 3, round-robin.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic        dmem_gnt = 1'b1;
  logic [31:0] dmem_rdata = '0;
  logic        fp_sel = 1'b0;
  logic        m0_req_fp, m1_req_fp;

  logic [3:0]  m0_gnt, m1_gnt, m0_rv, m1_rv, dreq, dwe, busy;
  logic [31:0] m0_rd [4];
  logic [31:0] m1_rd [4];
  logic [31:0] daddr [4];
  logic [31:0] dwdata [4];
  logic [3:0]  dbe [4];

  int errors = 0;
  int checks = 0;

  assign m0_req_fp = m0_req & fp_sel;
  assign m1_req_fp = m1_req & fp_sel;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_arbiter #(
      .MEM_LATENCY((g == 3) ? 3 : ((g == 2) ? 2 : 1)),
      .RR_EN((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .m0_req_i((g == 1) ? m0_req_fp : m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_be_i(m0_be), .m0_gnt_o(m0_gnt[g]),
      .m0_rvalid_o(m0_rv[g]), .m0_rdata_o(m0_rd[g]),
      .m1_req_i((g == 1) ? m1_req_fp : m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_be_i(m1_be), .m1_gnt_o(m1_gnt[g]),
      .m1_rvalid_o(m1_rv[g]), .m1_rdata_o(m1_rd[g]),
      .dmem_req_o(dreq[g]), .dmem_we_o(dwe[g]), .dmem_addr_o(daddr[g]),
      .dmem_wdata_o(dwdata[g]), .dmem_be_o(dbe[g]),
      .dmem_gnt_i(dmem_gnt), .dmem_rdata_i(dmem_rdata), .busy_o(busy[g])
    );
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    dmem_gnt = 1'b1; dmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    fp_sel = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    m0_req = 1'b1; m0_addr = 32'h55; m0_be = 4'hF;
    tick(); settle();
    checks++; if (m0_gnt[0] !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", m0_gnt[0]); end
    checks++; if (dreq[0] !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %b want 0", dreq[0]); end
    checks++; if (daddr[0] !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", daddr[0]); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
    checks++; if ({m0_rv, m1_rv} !== 8'h0) begin errors++; $display("FAIL reset_rvalid: got %h want 00", {m0_rv, m1_rv}); end
    m0_req = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_be = 4'hF;
    settle();
    checks++; if (m0_gnt[0] !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b want 1", m0_gnt[0]); end
    checks++; if (daddr[0] !== 32'h100) begin errors++; $display("FAIL load_addr: got %h want 100", daddr[0]); end
    checks++; if (dbe[0] !== 4'h0) begin errors++; $display("FAIL load_be: got %h want 0", dbe[0]); end
    checks++; if (m1_gnt[0] !== 1'b0) begin errors++; $display("FAIL load_m1_gnt: got %b want 0", m1_gnt[0]); end
    tick();
    m0_req = 1'b0; dmem_rdata = 32'hDEADBEEF;
    settle();
    checks++; if (m0_rv[0] !== 1'b1) begin errors++; $display("FAIL load_rvalid: got %b want 1", m0_rv[0]); end
    checks++; if (m0_rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", m0_rd[0]); end
    checks++; if (m1_rv[0] !== 1'b0 || m1_rd[0] !== 32'h0) begin errors++; $display("FAIL load_m1_quiet: got %b/%h want 0/0", m1_rv[0], m1_rd[0]); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL load_busy: got %b want 1", busy[0]); end
    tick();
    dmem_rdata = 32'h0;
    settle();
    checks++; if (m0_rv[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL load_done: got rv=%b busy=%b want 0/0", m0_rv[0], busy[0]); end
    do_reset();
  endtask

  task automatic test_contention();
    fp_sel = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h10; m0_be = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h20; m1_be = 4'hF;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (m0_gnt[0] !== (c % 2 == 0)) begin errors++; $display("FAIL rr_m0_gnt[%0d]: got %b want %b", c, m0_gnt[0], (c % 2 == 0)); end
      checks++; if (m1_gnt[0] !== (c % 2 == 1)) begin errors++; $display("FAIL rr_m1_gnt[%0d]: got %b want %b", c, m1_gnt[0], (c % 2 == 1)); end
      checks++; if ({m0_gnt[1], m1_gnt[1]} !== 2'b10) begin errors++; $display("FAIL fp_gnt[%0d]: got %b%b want 10", c, m0_gnt[1], m1_gnt[1]); end
      tick();
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h200; m0_wdata = 32'hCAFEF00D; m0_be = 4'b0011;
    settle();
    checks++; if (m0_gnt[2] !== 1'b1 || dwe[2] !== 1'b1) begin errors++; $display("FAIL b2b_store: got gnt=%b we=%b want 1/1", m0_gnt[2], dwe[2]); end
    checks++; if (dbe[2] !== 4'b0011 || dwdata[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_store_fields: got %h/%h want 3/cafef00d", dbe[2], dwdata[2]); end
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h204; m1_be = 4'hF;
    settle();
    checks++; if (m1_gnt[2] !== 1'b1 || daddr[2] !== 32'h204) begin errors++; $display("FAIL b2b_load: got gnt=%b addr=%h want 1/204", m1_gnt[2], daddr[2]); end
    checks++; if (dbe[2] !== 4'h0) begin errors++; $display("FAIL b2b_load_be: got %h want 0", dbe[2]); end
    tick();
    m1_req = 1'b0; dmem_rdata = 32'h11111111;
    settle();
    checks++; if (m0_rv[2] !== 1'b1 || m0_rd[2] !== 32'h0) begin errors++; $display("FAIL b2b_store_ack: got %b/%h want 1/0", m0_rv[2], m0_rd[2]); end
    checks++; if (m1_rv[2] !== 1'b0) begin errors++; $display("FAIL b2b_order1: got %b want 0", m1_rv[2]); end
    tick();
    dmem_rdata = 32'h12345678;
    settle();
    checks++; if (m1_rv[2] !== 1'b1 || m1_rd[2] !== 32'h12345678) begin errors++; $display("FAIL b2b_load_rsp: got %b/%h want 1/12345678", m1_rv[2], m1_rd[2]); end
    checks++; if (m0_rv[2] !== 1'b0 || m0_rd[2] !== 32'h0) begin errors++; $display("FAIL b2b_order2: got %b/%h want 0/0", m0_rv[2], m0_rd[2]); end
    tick();
    dmem_rdata = 32'h0;
    settle();
    checks++; if (m1_rv[2] !== 1'b0 || busy[2] !== 1'b0) begin errors++; $display("FAIL b2b_done: got rv=%b busy=%b want 0/0", m1_rv[2], busy[2]); end
    do_reset();
  endtask

  task automatic test_wait_states();
    m0_req = 1'b1; m0_addr = 32'h30; m0_be = 4'hF;
    settle();
    checks++; if (m0_gnt[0] !== 1'b1) begin errors++; $display("FAIL ws_first_gnt: got %b want 1", m0_gnt[0]); end
    tick();
    m0_addr = 32'h34;
    m1_req = 1'b1; m1_addr = 32'h40; m1_be = 4'hF;
    dmem_gnt = 1'b0; dmem_rdata = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if ({m0_gnt[0], m1_gnt[0]} !== 2'b00) begin errors++; $display("FAIL ws_no_gnt[%0d]: got %b%b want 00", c, m0_gnt[0], m1_gnt[0]); end
      checks++; if (daddr[0] !== 32'h40) begin errors++; $display("FAIL ws_pointer[%0d]: got addr %h want 40", c, daddr[0]); end
      if (c == 0) begin
        checks++; if (m0_rv[0] !== 1'b1 || m0_rd[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL ws_drain: got %b/%h want 1/a5a5a5a5", m0_rv[0], m0_rd[0]); end
      end
      tick();
      dmem_rdata = 32'h0;
    end
    dmem_gnt = 1'b1;
    settle();
    checks++; if ({m0_gnt[0], m1_gnt[0]} !== 2'b01) begin errors++; $display("FAIL ws_m1_gnt: got %b%b want 01", m0_gnt[0], m1_gnt[0]); end
    tick();
    m1_req = 1'b0; dmem_rdata = 32'h0BADCAFE;
    settle();
    checks++; if (m1_rv[0] !== 1'b1 || m1_rd[0] !== 32'h0BADCAFE) begin errors++; $display("FAIL ws_m1_rsp: got %b/%h want 1/0badcafe", m1_rv[0], m1_rd[0]); end
    checks++; if (m0_gnt[0] !== 1'b1) begin errors++; $display("FAIL ws_no_bubble: got %b want 1", m0_gnt[0]); end
    tick();
    do_reset();
  endtask

  task automatic test_reset_midflight();
    m0_req = 1'b1; m0_addr = 32'h300; m0_be = 4'hF;
    settle();
    checks++; if (m0_gnt[3] !== 1'b1) begin errors++; $display("FAIL mf_gnt0: got %b want 1", m0_gnt[3]); end
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h304; m1_be = 4'hF;
    settle();
    checks++; if (m1_gnt[3] !== 1'b1) begin errors++; $display("FAIL mf_gnt1: got %b want 1", m1_gnt[3]); end
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h308;
    rst_ni = 1'b0;
    settle();
    checks++; if ({m0_gnt[3], m1_gnt[3], dreq[3]} !== 3'b000) begin errors++; $display("FAIL mf_gnt_gated: got %b want 000", {m0_gnt[3], m1_gnt[3], dreq[3]}); end
    checks++; if (daddr[3] !== 32'h0) begin errors++; $display("FAIL mf_addr_gated: got %h want 0", daddr[3]); end
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL mf_busy: got %b want 0", busy[3]); end
    m0_req = 1'b0;
    settle();
    rst_ni = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({m0_rv[3], m1_rv[3], busy[3]} !== 3'b000) begin errors++; $display("FAIL mf_stale[%0d]: got rv0/rv1/busy=%b want 000", c, {m0_rv[3], m1_rv[3], busy[3]}); end
    end
    checks++; if (m0_rd[3] !== 32'h0 || m1_rd[3] !== 32'h0) begin errors++; $display("FAIL mf_rdata: got %h/%h want 0/0", m0_rd[3], m1_rd[3]); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_back_to_back();
    test_wait_states();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single-port data memory between the core load/store unit (master 0) and a secondary bus master (master 1, DMA/debug). Uses a req/gnt request handshake and an rvalid response returned after a fixed memory latency. Sits between the LSU/DMA byte-lane formatting logic and the DMEM macro; all addresses and byte-enables arrive already word-aligned and formatted.

Parameters:
MEM_LATENCY, 1, cycles from an accepted DMEM request to valid dmem_rdata_i; legal 1..3.
RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority, master 0 always wins.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
m0_req_i  input  1  master 0 request valid
m0_we_i  input  1  master 0 store (1) / load (0)
m0_addr_i  input  32  master 0 word-aligned address
m0_wdata_i  input  32  master 0 lane-shifted store data
m0_be_i  input  4  master 0 byte enables
m0_gnt_o  output  1  master 0 request accepted this cycle
m0_rvalid_o  output  1  master 0 response valid
m0_rdata_o  output  32  master 0 load data
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as master 0, for master 1
dmem_req_o  output  1  request to DMEM
dmem_we_o  output  1  DMEM write enable
dmem_addr_o  output  32  DMEM address
dmem_wdata_o  output  32  DMEM write data
dmem_be_o  output  4  DMEM byte enables; 4'b0000 when dmem_we_o=0
dmem_gnt_i  input  1  DMEM can accept this cycle (0 = wait state)
dmem_rdata_i  input  32  DMEM read data, valid MEM_LATENCY cycles after acceptance
busy_o  output  1  at least one response outstanding

Behaviour:
- Reset (rst_ni=0, asynchronous): response pipeline cleared, last-grant pointer = master 1 (so master 0 wins the first tie), busy_o=0. Because grants are combinational and gated by reset, all gnt/rvalid/dmem_req outputs are 0 and data outputs are 0 while in reset. Responses in flight are dropped, not replayed.
- Grant, same cycle, combinational: winner = sole requester; if both request, winner = master not granted last (RR_EN=1) or master 0 (RR_EN=0). Drive the winner's fields on the dmem_* outputs with dmem_req_o=1. mX_gnt_o = winner & dmem_gnt_i.
- The last-grant pointer updates only on an accepted request (dmem_req_o & dmem_gnt_i).
- Masters hold req and all fields stable until gnt. Request withdrawal before gnt is illegal (assertion).
- Accepted requests may issue every cycle. No bubble between masters. No limit on outstanding requests.
- Response pipeline: MEM_LATENCY-deep shift register of {valid, id, we}, written on acceptance. At the pipeline output:
  - m[id]_rvalid_o=1 for exactly one cycle, for both loads and stores (stores get a write acknowledge).
  - m[id]_rdata_o = dmem_rdata_i for loads, 32'h0 for stores.
  - The other master's rvalid_o=0 and rdata_o=0.
- Responses return strictly in acceptance order. An rvalid and a new gnt may coincide in the same cycle.
- dmem_gnt_i=0: no gnt_o asserted, pointer held, pipeline still shifts, so earlier responses still complete.
- busy_o = OR of the pipeline valid bits.

Test Plan:
- Single load: m0 requests addr 0x100, we=0, MEM_LATENCY=1, DMEM returns 0xDEADBEEF -> m0_gnt_o in cycle 0; m0_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1; m1 outputs stay 0.
- Contention after reset, both requesting for 4 cycles, RR_EN=1 -> grants alternate m0, m1, m0, m1. Same stimulus with RR_EN=0 -> m0 granted all 4 cycles, m1 starved.
- Back-to-back mix: m0 store 0x200/be 4'b0011, then m1 load 0x204, MEM_LATENCY=2 -> two accepts in consecutive cycles; m0 ack (rdata 0) then m1 load data on consecutive cycles, in order; dmem_be_o=0000 on the load.
- Wait states: m1 requesting, dmem_gnt_i low for 3 cycles -> no gnt and pointer unchanged. Then high -> m1 granted once, rvalid MEM_LATENCY cycles later.
- Reset mid-flight: MEM_LATENCY=3, two loads accepted, rst_ni pulled low one cycle later -> all outputs 0 immediately, busy_o=0. After release, no stale rvalid appears.
